cnt32_checker: RTL
==================

# cnt32_checker

Sequence checker for the receiving end of a free-running counter stream. Samples a WIDTH-bit count word, locks onto the sequence, and flags every valid sample that is not the previous valid sample plus one (mod 2^WIDTH). It sits after the counter source on validation builds and produces a lock indication, error counts and a first-failure capture for readout.

## Interface
- WIDTH, 32, width of the checked count word
- LOCK_COUNT, 4, consecutive matching samples after the seed sample required to declare lock (1..255)
- ERR_CNT_W, 16, width of the saturating error counter
- clk  in  1  clock; all logic on rising edge
- reset  in  1  reset, asynchronous, active-low
- din_valid  in  1  qualifies din; din is ignored when low
- din  in  WIDTH  received count word
- clear  in  1  synchronous clear of error status (err_count, err_sticky, capture registers); FSM unaffected
- locked  out  1  high while FSM in LOCKED
- err_pulse  out  1  one-cycle pulse per mismatch detected in LOCKED
- err_sticky  out  1  set on first mismatch, held until clear or reset
- err_count  out  ERR_CNT_W  number of mismatches, saturates at all-ones
- exp_cap  out  WIDTH  expected value at first mismatch since last clear/reset
- got_cap  out  WIDTH  received value at first mismatch since last clear/reset

## Operation
- Internal regs: state, ref (last valid sample, WIDTH), run (8-bit match counter).
- Expected value = ref + 1, truncated to WIDTH; all-ones followed by 0 is a match (wrap legal).
- Only cycles with din_valid=1 are samples; idle cycles do not advance ref or affect state.
- States:
  - SEARCH (reset state): on sample, ref<=din, run<=0, go ACQUIRE.
  - ACQUIRE: on sample, ref<=din always. Match: run<=run+1; if run+1==LOCK_COUNT go LOCKED. Mismatch: run<=0, stay ACQUIRE (din becomes new seed). No error reporting in this state.
  - LOCKED: on sample, ref<=din always. Match: stay. Mismatch: err_pulse, increment err_count, set err_sticky, capture if first, run<=0, go ACQUIRE (resync on received value).
- Capture: exp_cap/got_cap load only when err_sticky is 0 at the failing sample (first failure); later failures do not overwrite.
- err_count: saturates at 2^ERR_CNT_W-1; further mismatches still pulse err_pulse.
- clear: same cycle as a LOCKED mismatch -> clear applied first, then the new error: err_count=1, err_sticky=1, capture loads the new failure. clear alone -> err_count=0, err_sticky=0, exp_cap=0, got_cap=0.
- din_valid=0 never generates errors, regardless of din.

## Timing
- All outputs registered. Reset values: locked=0, err_pulse=0, err_sticky=0, err_count=0, exp_cap=0, got_cap=0; state=SEARCH, ref=0, run=0.
- Lock latency: locked rises on the edge sampling the (LOCK_COUNT+1)-th consecutive good sample (5th for default), visible from the next cycle.
- Error latency: err_pulse, err_count, err_sticky, captures and locked=0 all update on the edge sampling the bad word; err_pulse high exactly one cycle unless the next sample also errors (impossible: state is ACQUIRE after an error).
- Relock after error: LOCK_COUNT further matching samples after the bad word.
- Reset asserted mid-operation: all state and outputs return to reset values immediately (asynchronous); deassertion resumes in SEARCH.

## Test plan
- Reset, then 10 consecutive samples 0x00000010..0x00000019 -> locked=1 after 5th sample (0x14), err_count=0, err_sticky=0.
- Locked stream ..., 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001 -> no err_pulse, locked stays 1.
- Locked at 0x100, inject 0x105 instead of 0x101 -> one err_pulse, err_count=1, exp_cap=0x101, got_cap=0x105, locked=0; then 0x106..0x109 -> locked=1 again; second bad word leaves captures unchanged, err_count=2.
- Locked stream with din_valid toggling 1/0 and din randomized on invalid cycles -> no errors, lock held.
- ERR_CNT_W=4, 20 forced mismatches each separated by relock -> err_count=0xF, 20 err_pulses; then clear -> err_count=0, err_sticky=0, exp_cap=got_cap=0.
- Assert reset while locked with err_count=3 -> all outputs 0 immediately; after release first sample seeds SEARCH->ACQUIRE, no error.

Source files
------------

// File: rtl/cnt32_checker.sv
// cnt32_checker: sequence checker for a free-running counter stream.
// Seeds on the first valid word, locks after LOCK_COUNT consecutive +1 steps,
// and reports every out-of-sequence word seen while locked through a pulse,
// a saturating counter, a sticky flag and a first-failure capture.
`timescale 1ns/1ps

module cnt32_checker #(
   parameter int WIDTH      = 32,
   parameter int LOCK_COUNT = 4,
   parameter int ERR_CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 din_valid,
   input  logic [WIDTH-1:0]     din,
   input  logic                 clear,
   output logic                 locked,
   output logic                 err_pulse,
   output logic                 err_sticky,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic [WIDTH-1:0]     exp_cap,
   output logic [WIDTH-1:0]     got_cap
);

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   state_t               state_reg, state_next;
   logic [WIDTH-1:0]     ref_reg, ref_next;
   logic [7:0]           run_reg, run_next;

   logic [WIDTH-1:0]     exp_val;
   logic                 match;
   logic                 err_hit;

   logic                 locked_next;
   logic                 err_pulse_next;
   logic                 err_sticky_next;
   logic [ERR_CNT_W-1:0] err_count_next;
   logic [WIDTH-1:0]     exp_cap_next;
   logic [WIDTH-1:0]     got_cap_next;

   // Expected word wraps naturally at WIDTH bits, so all-ones -> 0 is legal.
   assign exp_val = ref_reg + WIDTH'(1);
   assign match   = (din == exp_val);

   // State register plus registered outputs; everything clears asynchronously.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= SEARCH;
         ref_reg    <= '0;
         run_reg    <= '0;
         locked     <= 1'b0;
         err_pulse  <= 1'b0;
         err_sticky <= 1'b0;
         err_count  <= '0;
         exp_cap    <= '0;
         got_cap    <= '0;
      end else begin
         state_reg  <= state_next;
         ref_reg    <= ref_next;
         run_reg    <= run_next;
         locked     <= locked_next;
         err_pulse  <= err_pulse_next;
         err_sticky <= err_sticky_next;
         err_count  <= err_count_next;
         exp_cap    <= exp_cap_next;
         got_cap    <= got_cap_next;
      end
   end

   // Next-state logic: only valid samples move the sequencer or the reference.
   always_comb begin
      state_next = state_reg;
      ref_next   = ref_reg;
      run_next   = run_reg;
      err_hit    = 1'b0;
      if (din_valid) begin
         // Every sample becomes the new reference, including a bad one (resync).
         ref_next = din;
         case (state_reg)
            SEARCH: begin
               run_next   = '0;
               state_next = ACQUIRE;
            end
            ACQUIRE: begin
               if (match) begin
                  run_next = run_reg + 8'd1;
                  if (({1'b0, run_reg} + 9'd1) == 9'(LOCK_COUNT))
                     state_next = LOCKED;
               end else begin
                  run_next = '0;
               end
            end
            LOCKED: begin
               if (!match) begin
                  err_hit    = 1'b1;
                  run_next   = '0;
                  state_next = ACQUIRE;
               end
            end
            default: begin
               run_next   = '0;
               state_next = SEARCH;
            end
         endcase
      end
   end

   // Output logic: clear is applied first, then any error of the same cycle.
   always_comb begin
      err_sticky_next = clear ? 1'b0 : err_sticky;
      err_count_next  = clear ? '0   : err_count;
      exp_cap_next    = clear ? '0   : exp_cap;
      got_cap_next    = clear ? '0   : got_cap;
      err_pulse_next  = err_hit;
      locked_next     = (state_next == LOCKED);
      if (err_hit) begin
         // Capture only the first failure since the last clear/reset.
         if (!err_sticky_next) begin
            exp_cap_next = exp_val;
            got_cap_next = din;
         end
         err_sticky_next = 1'b1;
         if (!(&err_count_next))
            err_count_next = err_count_next + ERR_CNT_W'(1);
      end
   end

endmodule
